// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry, vote helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

  // 2-of-3 majority
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Mid-bit sampler: captures the samples either side of the bit centre and votes 2-of-3.
// Latency: vote is combinational on the decision tick (counter OVERSAMPLE/2+1) using the live sample.
// Backpressure: none; samples only on baud ticks.
module uart_rx_vote
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_tick,
  input  logic             i_rx,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_vote
);

  localparam logic [CNT_W-1:0] CNT_LO  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OVERSAMPLE / 2);

  logic samp_lo_q;
  logic samp_mid_q;

  // Capture the two samples leading up to the decision tick; idle level is 1.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      samp_lo_q  <= 1'b1;
      samp_mid_q <= 1'b1;
    end else if (i_tick) begin
      if (i_cnt == CNT_LO)  samp_lo_q  <= i_rx;
      if (i_cnt == CNT_MID) samp_mid_q <= i_rx;
    end
  end

  // Third sample is the one present on the decision tick itself.
  always_comb begin
    o_vote = maj3(samp_lo_q, samp_mid_q, i_rx);
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversampled start detect, majority-voted bits, optional parity, 1/2 stop bits.
// Latency: word and flags appear one i_clk after the final stop-bit decision tick.
// Backpressure: o_valid/i_ready; a frame completing while an unaccepted word is held is dropped with an o_overrun pulse.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_rx_sync,
  input  logic                 i_baud_tick,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_stop2,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 prev_q;
  logic                 par_en_q, par_odd_q, stop2_q;
  logic                 par_err_q;
  logic                 vote;
  logic                 decide;
  logic                 start_ok, shift_en, par_chk, complete, cpl_ferr;

  uart_rx_vote #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_vote (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_tick (i_baud_tick),
    .i_rx   (i_rx_sync),
    .i_cnt  (cnt_q),
    .o_vote (vote)
  );

  assign decide = i_baud_tick && (cnt_q == CNT_DEC);
  assign o_busy = (state_q != ST_IDLE);

  // Frame state register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and per-tick datapath strobes; everything moves only on baud ticks.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    shift_en = 1'b0;
    par_chk  = 1'b0;
    complete = 1'b0;
    cpl_ferr = 1'b0;
    if (i_baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!i_rx_sync && prev_q) state_d = ST_START;
        end
        ST_START: begin
          if (decide) begin
            if (vote) begin
              state_d = ST_IDLE;
            end else begin
              state_d  = ST_DATA;
              start_ok = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (decide) begin
            shift_en = 1'b1;
            if (bit_q == BIT_LAST) state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (decide) begin
            par_chk = 1'b1;
            state_d = ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (decide) begin
            if (!vote) begin
              complete = 1'b1;
              cpl_ferr = 1'b1;
              state_d  = ST_WAIT_HIGH;
            end else if (stop2_q) begin
              state_d = ST_STOP2;
            end else begin
              complete = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        ST_STOP2: begin
          if (decide) begin
            complete = 1'b1;
            cpl_ferr = !vote;
            state_d  = vote ? ST_IDLE : ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (i_rx_sync) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Oversample counter: held at 0 in IDLE (so the edge tick clears it), free-running mod OVERSAMPLE in a frame.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt_q <= '0;
    end else if (i_baud_tick) begin
      if (state_q == ST_IDLE || state_d == ST_IDLE) cnt_q <= '0;
      else if (cnt_q == CNT_MAX)                    cnt_q <= '0;
      else                                          cnt_q <= cnt_q + 1'b1;
    end
  end

  // Previous-tick line sample for falling-edge start detection.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)          prev_q <= 1'b1;
    else if (i_baud_tick) prev_q <= i_rx_sync;
  end

  // Frame configuration is frozen once the start bit is confirmed.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (start_ok) begin
      par_en_q  <= i_parity_en;
      par_odd_q <= i_parity_odd;
      stop2_q   <= i_stop2;
    end
  end

  // LSB-first shift register, data-bit counter and parity check result.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      shreg_q   <= '0;
      bit_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        bit_q     <= '0;
        par_err_q <= 1'b0;
      end else if (shift_en) begin
        bit_q   <= bit_q + 1'b1;
        shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
      end else if (par_chk) begin
        par_err_q <= ((^shreg_q) ^ vote) != par_odd_q;
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (complete) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg_q;
          o_frame_err  <= cpl_ferr;
          o_parity_err <= par_err_q;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
